// File: rtl/rca_seq16_ctrl.sv
// rca_seq16_ctrl: sequential W-bit adder (W = 4*NIB) that reuses a single
// 4-bit ripple-carry adder, one nibble per cycle, LSB nibble first.
// Handshake: start_valid/start_ready to load operands, res_valid/res_ready
// to hand off the result.
// Optional feature: define RCA_SEQ_SUB_EN to add a 'sub' input that turns
// the operation into op_a - op_b (op_a + ~op_b + 1, cin ignored, cout=1
// meaning no borrow).

// 4-bit ripple-carry adder built from a chain of full adders.
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

  assign carry = c[4];

endmodule

module rca_seq16_ctrl #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [4*NIB-1:0]  op_a,
  input  logic [4*NIB-1:0]  op_b,
  input  logic              cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic              sub,
`endif
  output logic              res_valid,
  input  logic              res_ready,
  output logic [4*NIB-1:0]  result,
  output logic              cout,
  output logic              busy
);

  localparam int W  = 4 * NIB;
  localparam int IW = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [3:0]      nib_a, nib_b, nib_sum;
  logic            nib_carry;

  // Operand/carry as loaded on accept; subtraction pre-inverts op_b and
  // forces the carry-in so the datapath itself only ever adds.
  logic [W-1:0]    b_load;
  logic            c_load;

`ifdef RCA_SEQ_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1  : cin;
`else
  assign b_load = op_b;
  assign c_load = cin;
`endif

  // Select the current nibble of each registered operand.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  rca_4 u_rca (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d      = op_a;
          b_d      = b_load;
          carry_d  = c_load;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = nib_sum;
        end
        carry_d = nib_carry;
        if (idx_q == IW'(NIB - 1)) begin
          // Index wraps to 0 so it never goes past the last nibble.
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        // Result holds; no new request is taken here, only the hand-off.
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = result_q;
  assign cout        = carry_q;

endmodule

// File: doc/rca_seq16_ctrl.md
RCA_SEQ16_CTRL -- requirements
Module: rca_seq16_ctrl

Interface
REQ-001 Parameter NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB; NIB SHALL be >= 2.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port start_valid  input  1  request to begin an addition.
REQ-005 Port start_ready  output  1  block can accept a request.
REQ-006 Port op_a  input  W  augend, sampled on accept.
REQ-007 Port op_b  input  W  addend, sampled on accept.
REQ-008 Port cin  input  1  carry-in, sampled on accept.
REQ-009 Port res_valid  output  1  result and cout are valid.
REQ-010 Port res_ready  input  1  consumer accepts the result.
REQ-011 Port result  output  W  sum.
REQ-012 Port cout  output  1  carry out of bit W-1.
REQ-013 Port busy  output  1  high in RUN or DONE.

Function
REQ-014 The block SHALL instantiate exactly one rca_4 (a, b, cin, sum, carry) and compute the W-bit sum by time-multiplexing it one nibble per cycle, LSB nibble first.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; start_ready = (state==IDLE), res_valid = (state==DONE).
REQ-016 IDLE: on start_valid && start_ready, register op_a, op_b, carry register <= cin, nibble index <= 0, result <= 0, then go to RUN; start_valid when not ready SHALL be ignored.
REQ-017 RUN, each cycle: drive rca_4 with nibble[idx] of the registered operands and the carry register; on the edge, write sum into result[4*idx+3:4*idx], carry register <= carry, idx <= idx+1.
REQ-018 RUN -> DONE on the edge that writes idx == NIB-1; cout SHALL equal the carry register after that edge.
REQ-019 Latency: res_valid SHALL rise exactly NIB cycles after the accepting edge (4 cycles at default).
REQ-020 DONE: result and cout SHALL be held stable while res_ready is low; on res_valid && res_ready go to IDLE at the next edge.
REQ-021 No new request SHALL be accepted in DONE, even when res_ready is high in that cycle; the earliest next accept is the cycle after returning to IDLE.
REQ-022 Operand inputs changing during RUN or DONE SHALL NOT affect the in-flight result.
REQ-023 The nibble index SHALL be ceil(log2(NIB)) bits wide and SHALL never exceed NIB-1.

Reset
REQ-024 On rst high, asynchronously: state = IDLE, start_ready = 1, res_valid = 0, busy = 0, result = 0, cout = 0, idx = 0, carry register = 0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no res_valid pulse; the first accept after release SHALL behave as from power-up.

Configuration
REQ-026 Macro RCA_SEQ_SUB_EN: when defined, an input port sub (1 bit, sampled on accept) SHALL be added; with sub=1 the block SHALL compute op_a - op_b as op_a + ~op_b + 1, ignoring cin, with cout = 1 meaning no borrow.
REQ-027 Without RCA_SEQ_SUB_EN the port sub SHALL NOT exist and the block SHALL perform addition only.

Verification
REQ-028 0x0000 + 0x0000, cin=0 -> result 0x0000, cout 0, res_valid 4 cycles after accept.
REQ-029 0xFFFF + 0x0001, cin=0 -> result 0x0000, cout 1 (carry ripples across all nibbles); 0xFFFF + 0xFFFF, cin=1 -> 0xFFFF, cout 1.
REQ-030 0x1234 + 0x4321, cin=1 -> 0x5556, cout 0; operands changed mid-RUN -> result unchanged.
REQ-031 Hold res_ready low 5 cycles in DONE -> result and cout stable, start_valid ignored; res_ready high -> IDLE next cycle, start_ready 1.
REQ-032 Assert rst at second RUN cycle -> all outputs at reset values, no res_valid; next request 0x0F0F + 0x00F1 -> 0x1000, cout 0.
REQ-033 With RCA_SEQ_SUB_EN: sub=1, 0x0005 - 0x0007 -> 0xFFFE, cout 0; 0x0007 - 0x0005 -> 0x0002, cout 1.
